// File: rtl/ysyx_25030093_lsu_if.sv
// EXU/WBU handshake and word-wide memory bus of the load/store unit.
// slave is the LSU's own view, master is the surrounding pipeline/bus view.
interface ysyx_25030093_lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [31:0] in_rd_data;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  in_valid, in_op, in_addr, in_wdata, in_rd_data,
    input  out_ready, mem_gnt, mem_rvalid, mem_rdata,
    output in_ready, out_valid, out_data, out_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output in_valid, in_op, in_addr, in_wdata, in_rd_data,
    output out_ready, mem_gnt, mem_rvalid, mem_rdata,
    input  in_ready, out_valid, out_data, out_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/ysyx_25030093_lsu.sv
// Multi-cycle load/store unit: one op per handshake, at most one bus access,
// registered result with alignment/extension and fault flag for WBU.
module ysyx_25030093_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  rst,
  ysyx_25030093_lsu_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [31:0] TO = 32'(TIMEOUT);

  state_t      r_state, w_next;
  logic [4:0]  r_op;
  logic [1:0]  r_lane;
  logic [31:0] r_rd_data;
  logic [31:0] r_cnt;
  logic        r_out_valid, r_out_err;
  logic [31:0] r_out_data;
  logic        r_mem_req, r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_wstrb;

  logic        w_pass, w_store, w_illegal, w_timeout;

  function automatic logic is_illegal(input logic [4:0] op, input logic [1:0] a);
    logic [2:0] f;
    logic       ill;
    f   = op[2:0];
    ill = 1'b0;
    if (op[4:3] == 2'b01)
      ill = (f == 3'd3) || (f == 3'd6) || (f == 3'd7);
    else if (op[4:3] == 2'b10)
      ill = (f >= 3'd3);
    if (op[4] != op[3])
      ill = ill || ((f[1:0] == 2'b01) && a[0]) || ((f[1:0] == 2'b10) && (a != 2'b00));
    return ill;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f, input logic [1:0] lane,
                                               input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (f)
      3'd0:    res = 32'(b);
      3'd4:    res = {24'b0, b};
      3'd1:    res = 32'(h);
      3'd5:    res = {16'b0, h};
      default: res = rdata;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] sz, input logic [1:0] lane);
    logic [3:0] s;
    case (sz)
      2'b00:   s = 4'b0001 << lane;
      2'b01:   s = 4'b0011 << lane;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] d;
    case (sz)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  assign w_pass    = (bus.in_op[4] == bus.in_op[3]);
  assign w_store   = (bus.in_op[4:3] == 2'b10);
  assign w_illegal = is_illegal(bus.in_op, bus.in_addr[1:0]);
  // Timeout takes priority over a grant/response arriving in the final cycle.
  assign w_timeout = (TO != 32'd0) && (r_cnt + 32'd1 == TO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.in_valid) w_next = (w_pass || w_illegal) ? S_DONE : S_REQ;
      S_REQ:  if (w_timeout) w_next = S_DONE; else if (bus.mem_gnt) w_next = S_WAIT;
      S_WAIT: if (w_timeout || bus.mem_rvalid) w_next = S_DONE;
      S_DONE: if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= '0;
      r_lane      <= '0;
      r_rd_data   <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      r_out_data  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_op      <= bus.in_op;
          r_lane    <= bus.in_addr[1:0];
          r_rd_data <= bus.in_rd_data;
          r_cnt     <= '0;
          if (w_pass) begin
            r_out_valid <= 1'b1;
            r_out_err   <= 1'b0;
            r_out_data  <= bus.in_rd_data;
          end else if (w_illegal) begin
            r_out_valid <= 1'b1;
            r_out_err   <= 1'b1;
            r_out_data  <= '0;
          end else begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_store;
            r_mem_addr  <= {bus.in_addr[31:2], 2'b00};
            r_mem_wstrb <= w_store ? store_strb(bus.in_op[1:0], bus.in_addr[1:0]) : 4'b0000;
            r_mem_wdata <= w_store ? store_data(bus.in_op[1:0], bus.in_wdata) : 32'd0;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 32'd1;
          if (w_timeout) begin
            r_mem_req   <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_err   <= 1'b1;
            r_out_data  <= '0;
          end else if (bus.mem_gnt) begin
            r_mem_req <= 1'b0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 32'd1;
          if (w_timeout) begin
            r_out_valid <= 1'b1;
            r_out_err   <= 1'b1;
            r_out_data  <= '0;
          end else if (bus.mem_rvalid) begin
            r_out_valid <= 1'b1;
            r_out_err   <= 1'b0;
            r_out_data  <= (r_op[4:3] == 2'b10) ? r_rd_data
                                                : load_extract(r_op[2:0], r_lane, bus.mem_rdata);
          end
        end
        S_DONE: if (bus.out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_err   = r_out_err;
  assign bus.out_data  = r_out_data;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;

endmodule
